pattern_delay_timer: RTL



---
 rtl/pattern_delay_timer_if.sv | 23 ++
 rtl/pattern_delay_timer.sv | 116 +++++++++++
 2 files changed

// File: rtl/pattern_delay_timer_if.sv
// rtl/pattern_delay_timer_if.sv - serial control and user handshake bundle for pattern_delay_timer
interface pattern_delay_timer_if #(
  parameter int DELAY_W = 4
);
  logic               data;
  logic               data_valid;
  logic               ack;
  logic               shift_ena;
  logic               counting;
  logic               done;
  logic [DELAY_W-1:0] count;
  logic [3:0]         state_onehot;

  modport master (
    output data, data_valid, ack,
    input  shift_ena, counting, done, count, state_onehot
  );

  modport slave (
    input  data, data_valid, ack,
    output shift_ena, counting, done, count, state_onehot
  );
endinterface

// File: rtl/pattern_delay_timer.sv
// rtl/pattern_delay_timer.sv - start-pattern search, serial delay load, unit countdown, done/ack
module pattern_delay_timer #(
  parameter int                   PATTERN_W       = 4,
  parameter logic [PATTERN_W-1:0] PATTERN         = 4'b1101,
  parameter int                   DELAY_W         = 4,
  parameter int                   CYCLES_PER_UNIT = 1000
) (
  input  logic                  clk,
  input  logic                  reset,
  pattern_delay_timer_if.slave  bus
);

  localparam int FILL_W = $clog2(PATTERN_W + 1);
  localparam int BIT_W  = $clog2(DELAY_W + 1);
  localparam int UNIT_W = (CYCLES_PER_UNIT > 1) ? $clog2(CYCLES_PER_UNIT) : 1;
  localparam logic [UNIT_W-1:0] UNIT_LAST = UNIT_W'(CYCLES_PER_UNIT - 1);

  typedef enum logic [1:0] {
    S_SEARCH = 2'd0,
    S_SHIFT  = 2'd1,
    S_COUNT  = 2'd2,
    S_WAIT   = 2'd3
  } state_e;

  state_e               state_q;
  logic [PATTERN_W-1:0] hist_q;
  logic [FILL_W-1:0]    fill_q;
  logic [BIT_W-1:0]     bit_q;
  logic [UNIT_W-1:0]    unit_q;
  logic [DELAY_W-1:0]   count_q;

  logic [PATTERN_W-1:0] hist_d;
  logic [FILL_W-1:0]    fill_d;
  logic [DELAY_W-1:0]   count_d;
  logic                 match;

  // Single-bit widths have no "older" bits to keep, so the shift collapses to the new bit.
  if (PATTERN_W == 1) begin : g_hist1
    assign hist_d = bus.data;
  end else begin : g_histn
    assign hist_d = {hist_q[PATTERN_W-2:0], bus.data};
  end

  if (DELAY_W == 1) begin : g_cnt1
    assign count_d = bus.data;
  end else begin : g_cntn
    assign count_d = {count_q[DELAY_W-2:0], bus.data};
  end

  assign fill_d = (fill_q == FILL_W'(PATTERN_W)) ? fill_q : fill_q + FILL_W'(1);
  assign match  = (fill_d == FILL_W'(PATTERN_W)) && (hist_d == PATTERN);

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= S_SEARCH;
      hist_q  <= '0;
      fill_q  <= '0;
      bit_q   <= '0;
      unit_q  <= '0;
      count_q <= '0;
    end else begin
      case (state_q)
        S_SEARCH: begin
          if (bus.data_valid) begin
            hist_q <= hist_d;
            fill_q <= fill_d;
            if (match) begin
              state_q <= S_SHIFT;
              bit_q   <= '0;
            end
          end
        end
        S_SHIFT: begin
          if (bus.data_valid) begin
            count_q <= count_d;
            if (bit_q == BIT_W'(DELAY_W - 1)) begin
              state_q <= S_COUNT;
              bit_q   <= '0;
              unit_q  <= '0;
            end else begin
              bit_q <= bit_q + BIT_W'(1);
            end
          end
        end
        S_COUNT: begin
          // count==0 at the end of a unit means the final unit just elapsed.
          if (unit_q == UNIT_LAST) begin
            unit_q <= '0;
            if (count_q == '0) begin
              state_q <= S_WAIT;
            end else begin
              count_q <= count_q - DELAY_W'(1);
            end
          end else begin
            unit_q <= unit_q + UNIT_W'(1);
          end
        end
        S_WAIT: begin
          if (bus.ack) begin
            state_q <= S_SEARCH;
            hist_q  <= '0;
            fill_q  <= '0;
          end
        end
        default: state_q <= S_SEARCH;
      endcase
    end
  end

  assign bus.shift_ena    = (state_q == S_SHIFT) && bus.data_valid;
  assign bus.counting     = (state_q == S_COUNT);
  assign bus.done         = (state_q == S_WAIT);
  assign bus.count        = count_q;
  assign bus.state_onehot = 4'b0001 << state_q;

endmodule
